ex_hazard_unit: RTL and testbench

Hazard and forwarding controller for the 5-stage MIPS pipeline. It sits behind the ID/EX pipeline register and reads that register's outputs together with the decode-stage source fields. It drives the control signals in the opposite direction: PC/IF-ID stall, IF/ID and ID/EX flush, and the EX-stage forwarding mux selects. It keeps its own shadow copy of the destination information for the MEM and WB stages, plus saturating stall and flush event counters.

---
 rtl/mips_pipe_pkg.sv | 20 ++
 rtl/hazard_sat_counter.sv | 31 +++
 rtl/ex_hazard_unit.sv | 106 ++++++++++
 tb/tb_ex_hazard_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions: forwarding mux encodings, the zero register and
// the shadow-stage destination record.
package mips_pipe_pkg;

   localparam int unsigned REG_W = 5;
   localparam int unsigned FWD_W = 2;

   localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
   localparam logic [FWD_W-1:0] FWD_MEM = 2'b01;
   localparam logic [FWD_W-1:0] FWD_WB  = 2'b10;

   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [REG_W-1:0] rd;
      logic             regwr;
      logic             load;
   } shadow_t;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating event counter: counts cycles with inc high and holds at all-ones.
module hazard_sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/ex_hazard_unit.sv
// EX-stage hazard and forwarding controller: same-cycle stall/flush/forward
// selects from ID/EX plus a private MEM/WB destination shadow and event counters.
module ex_hazard_unit
   import mips_pipe_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic [REG_W-1:0] ex_rs,
   input  logic [REG_W-1:0] ex_rt,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_regwr,
   input  logic             ex_mem2reg,
   input  logic             ex_br_taken,
   output logic             stall,
   output logic             flush_if_id,
   output logic             flush_id_ex,
   output logic [FWD_W-1:0] fwd_a_sel,
   output logic [FWD_W-1:0] fwd_b_sel,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   shadow_t mem_q, mem_d;
   shadow_t wb_q,  wb_d;

   logic lu;
   logic br;

   // Shadow MEM/WB destination pipeline; a flushed ID/EX carries regwr=0.
   always_comb begin
      mem_d       = mem_q;
      wb_d        = wb_q;
      mem_d.rd    = ex_rd;
      mem_d.regwr = ex_regwr;
      mem_d.load  = ex_mem2reg;
      wb_d.rd     = mem_q.rd;
      wb_d.regwr  = mem_q.regwr;
      wb_d.load   = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end

   // Operand source select; MEM beats WB, loads in MEM and $0 never forward.
   function automatic logic [FWD_W-1:0] fwd_sel(input logic [REG_W-1:0] src,
                                                input shadow_t          mem,
                                                input shadow_t          wb);
      logic [FWD_W-1:0] sel;
      sel = FWD_RF;
      if (mem.regwr && !mem.load && (mem.rd != REG_ZERO) && (mem.rd == src)) begin
         sel = FWD_MEM;
      end else if (wb.regwr && (wb.rd != REG_ZERO) && (wb.rd == src)) begin
         sel = FWD_WB;
      end
      return sel;
   endfunction

   always_comb begin
      lu          = 1'b0;
      br          = 1'b0;
      stall       = 1'b0;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      fwd_a_sel   = FWD_RF;
      fwd_b_sel   = FWD_RF;
      if (!rst) begin
         lu = ex_regwr && ex_mem2reg && (ex_rd != REG_ZERO) &&
              ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
         br = ex_br_taken;
         // A taken branch kills the consumer anyway, so it overrides the stall.
         stall       = lu && !br;
         flush_if_id = br;
         flush_id_ex = br || lu;
         fwd_a_sel   = fwd_sel(ex_rs, mem_q, wb_q);
         fwd_b_sel   = fwd_sel(ex_rt, mem_q, wb_q);
      end
   end

   hazard_sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (stall),
      .cnt (stall_cnt)
   );

   hazard_sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .inc (br),
      .cnt (flush_cnt)
   );

endmodule

// File: tb/tb_ex_hazard_unit.sv
// Directed bench for ex_hazard_unit with a history-based reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_ex_hazard_unit;

   localparam int unsigned CW = 4;
   localparam int unsigned CMAX = 15;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [4:0]    id_rs = '0, id_rt = '0, ex_rs = '0, ex_rt = '0, ex_rd = '0;
   logic          id_use_rs = 1'b0, id_use_rt = 1'b0;
   logic          ex_regwr = 1'b0, ex_mem2reg = 1'b0, ex_br_taken = 1'b0;
   logic          stall, flush_if_id, flush_id_ex;
   logic [1:0]    fwd_a_sel, fwd_b_sel;
   logic [CW-1:0] stall_cnt, flush_cnt;

   int errors = 0;
   int checks = 0;

   ex_hazard_unit #(.CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
      .ex_regwr(ex_regwr), .ex_mem2reg(ex_mem2reg), .ex_br_taken(ex_br_taken),
      .stall(stall), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: what retired from EX one edge ago (MEM) and two edges ago (WB).
   int m_rd[2];
   bit m_wr[2];
   bit m_ld[2];
   int m_scnt, m_fcnt;

   function automatic int exp_fwd(input int src);
      if (m_wr[0] && !m_ld[0] && m_rd[0] != 0 && m_rd[0] == src) return 1;
      if (m_wr[1] && m_rd[1] != 0 && m_rd[1] == src) return 2;
      return 0;
   endfunction

   function automatic bit exp_lu();
      return ex_regwr && ex_mem2reg && ex_rd != 0 &&
             ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_rd[0] <= 0; m_rd[1] <= 0;
         m_wr[0] <= 1'b0; m_wr[1] <= 1'b0;
         m_ld[0] <= 1'b0; m_ld[1] <= 1'b0;
         m_scnt <= 0; m_fcnt <= 0;
      end else begin
         m_rd[0] <= int'(ex_rd); m_wr[0] <= ex_regwr; m_ld[0] <= ex_mem2reg;
         m_rd[1] <= m_rd[0];     m_wr[1] <= m_wr[0];  m_ld[1] <= m_ld[0];
         if (exp_lu() && !ex_br_taken && m_scnt < CMAX) m_scnt <= m_scnt + 1;
         if (ex_br_taken && m_fcnt < CMAX) m_fcnt <= m_fcnt + 1;
      end
   end

   // Per-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         check("m_stall",  int'(stall),       int'(exp_lu() && !ex_br_taken));
         check("m_fl_ifid", int'(flush_if_id), int'(ex_br_taken));
         check("m_fl_idex", int'(flush_id_ex), int'(exp_lu() || ex_br_taken));
         check("m_fwd_a",  int'(fwd_a_sel),   exp_fwd(int'(ex_rs)));
         check("m_fwd_b",  int'(fwd_b_sel),   exp_fwd(int'(ex_rt)));
         check("m_scnt",   int'(stall_cnt),   m_scnt);
         check("m_fcnt",   int'(flush_cnt),   m_fcnt);
      end
   end

   // Present one cycle of inputs just after a rising edge.
   task automatic drive(input int irs, input int irt, input bit urs, input bit urt,
                        input int ers, input int ert, input int erd,
                        input bit wr, input bit ld, input bit brt);
      id_rs = 5'(irs); id_rt = 5'(irt); id_use_rs = urs; id_use_rt = urt;
      ex_rs = 5'(ers); ex_rt = 5'(ert); ex_rd = 5'(erd);
      ex_regwr = wr; ex_mem2reg = ld; ex_br_taken = brt;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   initial begin
      // Reset forces outputs low even with hazardous inputs presented.
      drive(5, 5, 1, 1, 5, 5, 5, 1, 1, 1);
      #12;
      check("rst_stall", int'(stall), 0);
      check("rst_flush", int'(flush_if_id) + int'(flush_id_ex), 0);
      check("rst_fwd",   int'(fwd_a_sel) + int'(fwd_b_sel), 0);
      check("rst_cnt",   int'(stall_cnt) + int'(flush_cnt), 0);
      next_cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;

      // ALU dependency: add $3, then reader of $3 (and writer of $4), then reader of both.
      next_cycle(); drive(0, 0, 0, 0, 1, 2, 3, 1, 0, 0);
      next_cycle(); drive(0, 0, 0, 0, 3, 0, 4, 1, 0, 0);
      settle();
      check("alu_fwd_a_mem", int'(fwd_a_sel), 1);
      check("alu_stall", int'(stall), 0);
      next_cycle(); drive(0, 0, 0, 0, 3, 4, 6, 0, 0, 0);
      settle();
      check("alu_fwd_a_wb",  int'(fwd_a_sel), 2);
      check("alu_fwd_b_mem", int'(fwd_b_sel), 1);

      // Load-use: lw $5 in EX, consumer of $5 in ID.
      next_cycle(); drive(5, 0, 1, 0, 0, 0, 5, 1, 1, 0);
      settle();
      check("lu_stall", int'(stall), 1);
      check("lu_flush_idex", int'(flush_id_ex), 1);
      check("lu_flush_ifid", int'(flush_if_id), 0);
      next_cycle(); drive(5, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      check("lu_scnt", int'(stall_cnt), 1);
      settle();
      check("lu_bubble_stall", int'(stall), 0);
      next_cycle(); drive(0, 0, 0, 0, 5, 0, 8, 1, 0, 0);
      settle();
      check("lu_fwd_a_wb", int'(fwd_a_sel), 2);

      // $0 destination and an unused source field never stall.
      next_cycle(); drive(0, 0, 1, 1, 0, 0, 0, 1, 1, 0);
      settle();
      check("zero_stall", int'(stall), 0);
      next_cycle(); drive(1, 7, 1, 0, 0, 0, 7, 1, 1, 0);
      settle();
      check("unused_rt_stall", int'(stall), 0);
      check("zero_fwd", int'(fwd_a_sel), 0);
      // Load $7 now in MEM must not forward via 01; then it reaches WB.
      next_cycle(); drive(0, 0, 0, 0, 7, 7, 0, 0, 0, 0);
      settle();
      check("load_mem_nofwd", int'(fwd_a_sel), 0);
      next_cycle(); drive(0, 0, 0, 0, 7, 0, 0, 0, 0, 0);
      settle();
      check("load_wb_fwd", int'(fwd_a_sel), 2);

      // Branch taken together with load-use: no stall, both flushes.
      next_cycle(); drive(5, 0, 1, 0, 0, 0, 5, 1, 1, 1);
      settle();
      check("br_stall", int'(stall), 0);
      check("br_flushes", int'(flush_if_id) + int'(flush_id_ex), 2);
      next_cycle(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("br_fcnt", int'(flush_cnt), 1);
      check("br_scnt", int'(stall_cnt), 1);

      // Saturation: 20 load-use stalls on a 4-bit counter.
      for (int i = 0; i < 20; i++) begin
         drive(9, 0, 1, 0, 0, 0, 9, 1, 1, 0);
         next_cycle();
      end
      check("sat_scnt", int'(stall_cnt), 15);

      // Async reset while forwarding is active.
      drive(0, 0, 0, 0, 0, 0, 11, 1, 0, 0);
      next_cycle(); drive(0, 0, 0, 0, 11, 11, 0, 0, 0, 0);
      #1;
      check("pre_rst_fwd", int'(fwd_a_sel), 1);
      drive(11, 0, 1, 0, 11, 11, 11, 1, 1, 1);
      rst = 1'b1;
      #1;
      check("arst_fwd",  int'(fwd_a_sel) + int'(fwd_b_sel), 0);
      check("arst_ctl",  int'(stall) + int'(flush_if_id) + int'(flush_id_ex), 0);
      check("arst_cnt",  int'(stall_cnt) + int'(flush_cnt), 0);
      next_cycle();
      drive(0, 0, 0, 0, 11, 11, 0, 0, 0, 0);
      rst = 1'b0;
      settle();
      check("post_rst_fwd", int'(fwd_a_sel) + int'(fwd_b_sel), 0);
      next_cycle();
      next_cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
